// File: rtl/mret_return_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mret_return_ctrl
// Purpose  : mret trap-return sequencer. It issues a one-cycle redirect to the
//            aligned mepc, flushes the front end and restores MIE from MPIE.
//            The optional interrupt shadow during refill is enabled by the
//            MRET_IRQ_SHADOW_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module mret_return_ctrl #(
    parameter int REFILL_CYCLES  = 4,
    parameter int RESET_PC_ALIGN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mret_mem,
    input  logic        trap_taken,
    input  logic [31:0] mepc_i,
    input  logic        mpie_i,
    output logic        pc_redirect_valid,
    output logic [31:0] pc_redirect_adr,
    output logic        flush_front,
    output logic        clear_counter,
    output logic        mstatus_wen,
    output logic        mie_o,
    output logic        mpie_o,
    output logic        irq_mask,
    output logic        busy
);

    localparam logic [31:0] c_align_mask = ~((32'd1 << RESET_PC_ALIGN) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_REFILL   = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_mepc;
    logic        r_mpie;
    logic        w_redirect;

`ifdef MRET_IRQ_SHADOW_EN
    localparam logic [2:0] c_rcnt_last = 3'(REFILL_CYCLES - 1);
    logic [2:0] r_rcnt;
`endif

    // Legal REFILL_CYCLES is 1..7; this block only elaborates on a bad setting.
    if (REFILL_CYCLES < 1 || REFILL_CYCLES > 7) begin : g_refill_cycles_out_of_range
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mepc  <= '0;
            r_mpie  <= 1'b0;
`ifdef MRET_IRQ_SHADOW_EN
            r_rcnt  <= '0;
`endif
        end else if (trap_taken) begin
            // Trap entry owns the pipeline: any pending return is abandoned.
            r_state <= S_IDLE;
`ifdef MRET_IRQ_SHADOW_EN
            r_rcnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mret_mem) begin
                        r_mepc  <= mepc_i;
                        r_mpie  <= mpie_i;
                        r_state <= S_REDIRECT;
                    end
                end
                S_REDIRECT: begin
`ifdef MRET_IRQ_SHADOW_EN
                    r_rcnt  <= '0;
                    r_state <= S_REFILL;
`else
                    r_state <= S_IDLE;
`endif
                end
`ifdef MRET_IRQ_SHADOW_EN
                S_REFILL: begin
                    if (mret_mem) begin
                        // Back-to-back return: REDIRECT reloads rcnt, restarting the shadow.
                        r_mepc  <= mepc_i;
                        r_mpie  <= mpie_i;
                        r_state <= S_REDIRECT;
                    end else if (r_rcnt == c_rcnt_last) begin
                        r_rcnt  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rcnt  <= r_rcnt + 3'd1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_redirect        = (r_state == S_REDIRECT);
    assign pc_redirect_valid = w_redirect;
    assign flush_front       = w_redirect;
    assign clear_counter     = w_redirect;
    assign mstatus_wen       = w_redirect;
    assign mpie_o            = w_redirect;
    assign mie_o             = w_redirect & r_mpie;
    assign pc_redirect_adr   = r_mepc & c_align_mask;
    assign busy              = (r_state != S_IDLE);

`ifdef MRET_IRQ_SHADOW_EN
    assign irq_mask = (r_state == S_REFILL) || (r_state == S_REDIRECT);
`else
    assign irq_mask = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/mret_return_ctrl.md
# mret_return_ctrl

Trap-return sequencer for the CSR datapath. When an `mret` reaches the MEM/CSR stage, it latches `mepc` and issues a one-cycle fetch redirect to that address. On the same cycle it flushes IF1/IF2/ID/EXE, restores `mstatus.MIE` from `MPIE`, and pulses `clear_counter` to the mepc-capture selector. It then holds off interrupts while the pipeline refills. It sits beside the trap-entry path in the CSR block and is the return-side counterpart of mepc capture.

## Interface
Parameters:
- `REFILL_CYCLES`, default 4: number of cycles for which interrupts stay masked after the redirect (legal range 1..7).
- `RESET_PC_ALIGN`, default 2: number of low address bits forced to zero on redirect (2 gives word alignment, 1 gives halfword alignment).

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous reset, active-high.
- `mret_mem`, input, 1: a valid `mret` is in the MEM/CSR stage this cycle.
- `trap_taken`, input, 1: trap entry is committing this cycle; it has priority over everything else.
- `mepc_i`, input, 32: current `mepc` CSR value.
- `mpie_i`, input, 1: current `mstatus.MPIE`.
- `pc_redirect_valid`, output, 1: fetch must load `pc_redirect_adr` this cycle.
- `pc_redirect_adr`, output, 32: return target.
- `flush_front`, output, 1: squash IF1, IF2, ID and EXE.
- `clear_counter`, output, 1: restart the mepc-capture stage counter.
- `mstatus_wen`, output, 1: write strobe for the MIE/MPIE update.
- `mie_o`, output, 1: new `mstatus.MIE` value.
- `mpie_o`, output, 1: new `mstatus.MPIE` value (always 1).
- `irq_mask`, output, 1: block interrupt recognition.
- `busy`, output, 1: the sequencer is not in IDLE.

## Operation
States: IDLE, REDIRECT and REFILL, with a 3-bit refill counter `rcnt`.
- **IDLE:**
  - On `mret_mem=1` with `trap_taken=0`: latch `mepc_i` and `mpie_i`, then go to REDIRECT.
  - Otherwise stay in IDLE.
- **REDIRECT** (exactly one cycle):
  - Asserts `pc_redirect_valid`, `flush_front`, `clear_counter` and `mstatus_wen`.
  - `pc_redirect_adr` is the latched mepc with the low `RESET_PC_ALIGN` bits zeroed.
  - `mie_o` is the latched MPIE; `mpie_o` is 1.
  - Loads `rcnt` with 0 and moves to REFILL.
- **REFILL:**
  - Increments `rcnt` each cycle.
  - When `rcnt == REFILL_CYCLES-1`, returns to IDLE.
  - If `mret_mem=1` arrives here, it is accepted: mepc is re-latched and the state goes back to REDIRECT, restarting the refill.
- **Any state with `trap_taken=1`:**
  - The next state is IDLE.
  - Any pending REDIRECT is cancelled and produces no strobes.
  - `rcnt` is cleared.
- **Simultaneous `trap_taken` and `mret_mem`:** the trap wins and the `mret` is dropped.
- **Output decoding:**
  - `busy = (state != IDLE)`.
  - `irq_mask = (state == REFILL) || (state == REDIRECT)`.
- **Widths:** the mepc alignment is a pure bit-clear; there is no arithmetic on the address.

## Timing
- All outputs are decoded from registered state and latched data; there are no combinational paths from input to output.
- Latency from `mret_mem` sampled high at edge N:
  - REDIRECT strobes are high during cycle N+1.
  - REFILL covers cycles N+2 through N+1+`REFILL_CYCLES`.
  - IDLE resumes at N+2+`REFILL_CYCLES`.
- `trap_taken` sampled at edge N forces IDLE from cycle N+1. If the sequencer was in REDIRECT during cycle N, that redirect has already been issued.
- While `reset` is high, asynchronously: state is IDLE, `rcnt=0`, latched mepc is 0, latched MPIE is 0. All outputs are 0, including `pc_redirect_adr`.
- Reset asserted mid-sequence aborts immediately. No partial strobe follows its release.

## Configuration
- Macro: `MRET_IRQ_SHADOW_EN`.
- **Defined:**
  - `irq_mask` behaves as described in Operation.
  - The REFILL state and `rcnt` exist.
- **Undefined:**
  - `irq_mask` is tied to 0.
  - The REFILL state is removed: REDIRECT returns directly to IDLE.
  - `busy` is high only during REDIRECT.
  - `REFILL_CYCLES` is ignored.

## Test plan
- **Reset values:** assert `reset` asynchronously mid-REFILL → all outputs are 0 and state is IDLE within the same cycle. After release, `busy` stays 0 until a new `mret_mem`.
- **Basic return:** `mepc_i=0x0000_1236`, `mpie_i=1`, one-cycle `mret_mem` → next cycle `pc_redirect_valid=1`, `pc_redirect_adr=0x0000_1234`, `flush_front=clear_counter=mstatus_wen=1`, `mie_o=1`, `mpie_o=1`. With the macro defined, `irq_mask=1` for 5 cycles total at the default `REFILL_CYCLES`.
- **mepc latched:** change `mepc_i` to `0xDEAD_BEEF` in the cycle after `mret_mem` → redirect address is still `0x0000_1234`.
- **Priority:** `trap_taken` and `mret_mem` asserted together → no redirect and `busy` stays 0. Separately, `trap_taken` during REFILL → IDLE next cycle and `irq_mask` drops.
- **Back-to-back:** second `mret_mem` at REFILL cycle 2 with `mepc_i=0x200` → a new redirect to `0x200` and the refill count restarts from 0.
- **Macro undefined:** basic return → `irq_mask` is always 0 and `busy` is high for exactly 1 cycle.
